regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port (dataIn / dataInRegister / enableSavingDataIn) between two write-back requesters: req0 = ALU result path, req1 = memory-load path.
- Round-robin arbitration with valid/ready handshakes drives the port from registered outputs.
- Maintains a pending-write scoreboard so decode can stall when a read address has an outstanding write.
- Sits between the execute/memory stages and the register file.

Parameters:
- DATA_WIDTH, 32, width of write data.
- ADDR_WIDTH, 4, register address width.
- NUM_REGS, 16, number of registers; must equal 2**ADDR_WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  ALU write-back request.
- req0_reg  in  ADDR_WIDTH  ALU destination register.
- req0_data  in  DATA_WIDTH  ALU write data.
- req0_ready  out  1  ALU request accepted this cycle.
- req1_valid  in  1  load write-back request.
- req1_reg  in  ADDR_WIDTH  load destination register.
- req1_data  in  DATA_WIDTH  load write data.
- req1_ready  out  1  load request accepted this cycle.
- reserve_valid  in  1  decode issues an instruction that will write reserve_reg.
- reserve_reg  in  ADDR_WIDTH  register to mark pending.
- rd_addr_a  in  ADDR_WIDTH  decode read address A.
- rd_addr_b  in  ADDR_WIDTH  decode read address B.
- rd_stall  out  1  rd_addr_a or rd_addr_b has a pending write.
- pending  out  NUM_REGS  scoreboard vector; bit r = write to r outstanding.
- wr_data  out  DATA_WIDTH  to register file dataIn.
- wr_reg  out  ADDR_WIDTH  to register file dataInRegister.
- wr_en  out  1  to register file enableSavingDataIn.

Behaviour:
- Reset (async, rst_n=0): wr_en=0, wr_data=0, wr_reg=0, pending=0, last_grant=1 (req0 wins the first conflict). Outputs stay at these values for as long as rst_n is low.
- Handshake: a transfer occurs on a rising edge where reqN_valid && reqN_ready. Requesters hold valid, reg and data stable until accepted.
- readyN is combinational from the valid inputs and last_grant. There is no backpressure from the register file, so the port accepts one request per cycle.
  - Only req0 valid: req0_ready=1.
  - Only req1 valid: req1_ready=1.
  - Both valid: grant the requester not equal to last_grant.
  - At most one ready is high per cycle.
- last_grant updates to the granted index on every transfer. It holds when no transfer occurs.
- Write-port latency is one cycle. On the edge that accepts a transfer, register wr_data, wr_reg and wr_en=1 from the winner. With no transfer, wr_en=0 next cycle; wr_data and wr_reg hold.
- The register file captures the write on the edge after wr_en rises.
- Scoreboard: a pending bit clears on the edge where wr_en=1 for wr_reg, i.e. the cycle the register file commits the write.
- reserve_valid sets pending[reserve_reg] on the edge.
- Simultaneous reserve and clear on the same register: set wins, because a new producer has been issued.
- Reserving an already-pending register leaves it pending (single-bit scoreboard). Decode must not issue a second producer for a pending register.
- rd_stall is combinational: pending[rd_addr_a] | pending[rd_addr_b]. There is no bypass; a read stalls until the cycle after commit.
- A write to a non-pending register is legal. It performs the write and leaves pending unchanged (bit stays 0).
- Register 0 is an ordinary writable register; there is no special case.
- Reset asserted mid-transfer: the in-flight wr_en is dropped and all pending bits clear. Upstream must flush in step.

Decomposition:
- Shared package / include: DATA_WIDTH, ADDR_WIDTH, NUM_REGS defaults, and the requester index constants REQ_ALU=0, REQ_LOAD=1.
- One sub-module: regfile_scoreboard. It holds the pending vector with set/clear priority and both rd_stall lookups.
- Arbitration and the output register stay in the top module.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then release with no requests -> wr_en=0, pending=16'h0000, both readys 0.
- Single ALU write: req0 reg=5, data=50 for one cycle -> req0_ready=1 that cycle; next cycle wr_en=1, wr_reg=5, wr_data=50; cycle after that wr_en=0.
- Conflict fairness: req0 (reg=3, data=30) and req1 (reg=7, data=70) held valid together from reset -> req0 granted first, req1 next cycle. Continuous valid on both yields a strictly alternating 0,1,0,1 grant sequence.
- Scoreboard stall: reserve reg=9, then rd_addr_a=9 -> rd_stall=1. After req1 writes reg 9 (data 999), rd_stall drops the cycle after wr_en=1 with wr_reg=9. rd_addr_b=2 never stalls.
- Same-cycle set/clear: reg 4 pending; its write commits on the same edge as reserve_valid reg=4 -> pending[4] remains 1.
- Reset mid-operation: reserve regs 1..15, start a req0 write, assert rst_n=0 asynchronously between edges -> wr_en=0 and pending=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared sizing defaults and requester indices for the register-file write arbiter.
package regfile_write_arbiter_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_NUM_REGS   = 16;

  // Requester indices, also the encoding of the last-grant register.
  localparam logic REQ_ALU  = 1'b0;
  localparam logic REQ_LOAD = 1'b1;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by decode, cleared on commit.
// Set beats clear on the same register because a newer producer was just issued.
module regfile_scoreboard
  import regfile_write_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_REGS   = DEF_NUM_REGS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set_i,
  input  logic [ADDR_WIDTH-1:0] set_reg_i,
  input  logic                  clr_i,
  input  logic [ADDR_WIDTH-1:0] clr_reg_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b_i,
  output logic                  rd_stall_o,
  output logic [NUM_REGS-1:0]   pending_o
);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

  always_comb begin
    pending_d = pending_q;
    if (clr_i) pending_d[clr_reg_i] = 1'b0;
    if (set_i) pending_d[set_reg_i] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  assign rd_stall_o = pending_q[rd_addr_a_i] | pending_q[rd_addr_b_i];
  assign pending_o  = pending_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and load write-back.
// One-cycle registered write port; readies are combinational, one transfer per cycle.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_REGS   = DEF_NUM_REGS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_reg,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_reg,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  input  logic                  reserve_valid,
  input  logic [ADDR_WIDTH-1:0] reserve_reg,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic                  rd_stall,
  output logic [NUM_REGS-1:0]   pending,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [ADDR_WIDTH-1:0] wr_reg,
  output logic                  wr_en
);

  logic                  last_grant_q, last_grant_d;
  logic                  wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [ADDR_WIDTH-1:0] wr_reg_q, wr_reg_d;
  logic                  gnt0, gnt1;

  // On conflict the requester that did not win last time gets the port.
  assign gnt0 = req0_valid && (!req1_valid || (last_grant_q == REQ_LOAD));
  assign gnt1 = req1_valid && (!req0_valid || (last_grant_q == REQ_ALU));

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_comb begin
    last_grant_d = last_grant_q;
    wr_en_d      = 1'b0;
    wr_data_d    = wr_data_q;
    wr_reg_d     = wr_reg_q;
    if (gnt0) begin
      last_grant_d = REQ_ALU;
      wr_en_d      = 1'b1;
      wr_data_d    = req0_data;
      wr_reg_d     = req0_reg;
    end else if (gnt1) begin
      last_grant_d = REQ_LOAD;
      wr_en_d      = 1'b1;
      wr_data_d    = req1_data;
      wr_reg_d     = req1_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= REQ_LOAD;
      wr_en_q      <= 1'b0;
      wr_data_q    <= '0;
      wr_reg_q     <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      wr_en_q      <= wr_en_d;
      wr_data_q    <= wr_data_d;
      wr_reg_q     <= wr_reg_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_data = wr_data_q;
  assign wr_reg  = wr_reg_q;

  // The register file commits while wr_en is high, so that is when the pending bit retires.
  regfile_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .set_i       (reserve_valid),
    .set_reg_i   (reserve_reg),
    .clr_i       (wr_en_q),
    .clr_reg_i   (wr_reg_q),
    .rd_addr_a_i (rd_addr_a),
    .rd_addr_b_i (rd_addr_b),
    .rd_stall_o  (rd_stall),
    .pending_o   (pending)
  );

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: expected writes queued at grant, checked at the write port.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0]  req0_reg, req1_reg, reserve_reg, rd_addr_a, rd_addr_b, wr_reg;
  logic [31:0] req0_data, req1_data, wr_data;
  logic        reserve_valid, rd_stall, wr_en;
  logic [15:0] pending;

  typedef struct {
    logic [3:0]  r;
    logic [31:0] d;
  } wr_t;

  wr_t  exp_q[$];
  wr_t  got;
  logic exp_last;
  logic [1:0] g;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_reg(req0_reg), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_reg(req1_reg), .req1_data(req1_data), .req1_ready(req1_ready),
    .reserve_valid(reserve_valid), .reserve_reg(reserve_reg),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_stall(rd_stall), .pending(pending),
    .wr_data(wr_data), .wr_reg(wr_reg), .wr_en(wr_en)
  );

  // Reference grant: {g1, g0}
  function automatic logic [1:0] exp_gnt(input logic v0, input logic v1, input logic last);
    logic g0, g1;
    if (v0 && v1) begin
      g0 = (last == 1'b1);
      g1 = (last == 1'b0);
    end else begin
      g0 = v0;
      g1 = v1;
    end
    return {g1, g0};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; req0_reg = 0; req1_reg = 0; req0_data = 0; req1_data = 0;
    reserve_valid = 0; reserve_reg = 0; rd_addr_a = 0; rd_addr_b = 0;
    exp_last = 1'b1;
    tick; tick;
    tests_run++;
    if (wr_en !== 1'b0 || wr_data !== 32'd0 || wr_reg !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_wr_port: wr_en=%0b wr_data=%0h wr_reg=%0d, need 0/0/0", wr_en, wr_data, wr_reg);
    end
    tests_run++;
    if (pending !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_pending: got %h need 0000", pending);
    end
    rst_n = 1'b1;
    tick;
    tests_run++;
    if (wr_en !== 1'b0 || pending !== 16'h0000 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle: wr_en=%0b pending=%h rdy0=%0b rdy1=%0b, need 0/0000/0/0",
               wr_en, pending, req0_ready, req1_ready);
    end
  endtask

  task automatic test_single_alu;
    req0_valid = 1; req0_reg = 5; req0_data = 50;
    #1;
    g = exp_gnt(1'b1, 1'b0, exp_last);
    tests_run++;
    if ({req1_ready, req0_ready} !== g) begin
      tests_failed++;
      $display("FAIL single_ready: got %b need %b", {req1_ready, req0_ready}, g);
    end
    if (g[0]) begin exp_q.push_back('{r: 4'd5, d: 32'd50}); exp_last = 1'b0; end
    tick;
    req0_valid = 0;
    tests_run++;
    if (wr_en !== 1'b1 || exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL single_wr_en: wr_en=%0b queued=%0d, need 1 with a queued write", wr_en, exp_q.size());
    end else begin
      got = exp_q.pop_front();
      if (wr_reg !== got.r || wr_data !== got.d) begin
        tests_failed++;
        $display("FAIL single_wr: reg=%0d data=%0d need reg=%0d data=%0d", wr_reg, wr_data, got.r, got.d);
      end
    end
    tick;
    tests_run++;
    if (wr_en !== 1'b0 || wr_reg !== 4'd5 || wr_data !== 32'd50) begin
      tests_failed++;
      $display("FAIL single_idle_hold: wr_en=%0b reg=%0d data=%0d need 0/5/50", wr_en, wr_reg, wr_data);
    end
  endtask

  task automatic test_conflict;
    rst_n = 1'b0;
    exp_last = 1'b1;
    req0_valid = 1; req0_reg = 3; req0_data = 30;
    req1_valid = 1; req1_reg = 7; req1_data = 70;
    #1;
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      g = exp_gnt(1'b1, 1'b1, exp_last);
      tests_run++;
      if ({req1_ready, req0_ready} !== g || req1_ready !== i[0]) begin
        tests_failed++;
        $display("FAIL conflict_grant[%0d]: got %b need %b", i, {req1_ready, req0_ready}, g);
      end
      if (g[0]) begin exp_q.push_back('{r: 4'd3, d: 32'd30}); exp_last = 1'b0; end
      else if (g[1]) begin exp_q.push_back('{r: 4'd7, d: 32'd70}); exp_last = 1'b1; end
      tick;
      tests_run++;
      if (wr_en !== 1'b1 || exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL conflict_wr_en[%0d]: wr_en=%0b queued=%0d need 1", i, wr_en, exp_q.size());
      end else begin
        got = exp_q.pop_front();
        if (wr_reg !== got.r || wr_data !== got.d) begin
          tests_failed++;
          $display("FAIL conflict_wr[%0d]: reg=%0d data=%0d need reg=%0d data=%0d",
                   i, wr_reg, wr_data, got.r, got.d);
        end
      end
    end
    req0_valid = 0; req1_valid = 0;
    tick;
    tests_run++;
    if (wr_en !== 1'b0 || pending !== 16'h0000) begin
      tests_failed++;
      $display("FAIL conflict_drain: wr_en=%0b pending=%h need 0/0000", wr_en, pending);
    end
  endtask

  task automatic test_stall;
    reserve_valid = 1; reserve_reg = 9; rd_addr_a = 9; rd_addr_b = 2;
    tick;
    reserve_valid = 0;
    tests_run++;
    if (pending !== 16'h0200 || rd_stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_set: pending=%h stall=%0b need 0200/1", pending, rd_stall);
    end
    rd_addr_a = 0;
    #1;
    tests_run++;
    if (rd_stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_b_clear: stall=%0b need 0", rd_stall);
    end
    rd_addr_a = 9;
    req1_valid = 1; req1_reg = 9; req1_data = 999;
    #1;
    g = exp_gnt(1'b0, 1'b1, exp_last);
    tests_run++;
    if ({req1_ready, req0_ready} !== g) begin
      tests_failed++;
      $display("FAIL stall_ready: got %b need %b", {req1_ready, req0_ready}, g);
    end
    if (g[1]) begin exp_q.push_back('{r: 4'd9, d: 32'd999}); exp_last = 1'b1; end
    tick;
    req1_valid = 0;
    tests_run++;
    if (wr_en !== 1'b1 || exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL stall_wr_en: wr_en=%0b queued=%0d need 1", wr_en, exp_q.size());
    end else begin
      got = exp_q.pop_front();
      if (wr_reg !== got.r || wr_data !== got.d || rd_stall !== 1'b1) begin
        tests_failed++;
        $display("FAIL stall_commit_cycle: reg=%0d data=%0d stall=%0b need reg=%0d data=%0d stall=1",
                 wr_reg, wr_data, rd_stall, got.r, got.d);
      end
    end
    tick;
    tests_run++;
    if (rd_stall !== 1'b0 || pending !== 16'h0000) begin
      tests_failed++;
      $display("FAIL stall_release: stall=%0b pending=%h need 0/0000", rd_stall, pending);
    end
  endtask

  task automatic test_set_clear;
    reserve_valid = 1; reserve_reg = 4;
    tick;
    reserve_valid = 0;
    req0_valid = 1; req0_reg = 4; req0_data = 44;
    #1;
    g = exp_gnt(1'b1, 1'b0, exp_last);
    tests_run++;
    if ({req1_ready, req0_ready} !== g || pending !== 16'h0010) begin
      tests_failed++;
      $display("FAIL setclr_pre: ready=%b pending=%h need %b/0010", {req1_ready, req0_ready}, pending, g);
    end
    if (g[0]) begin exp_q.push_back('{r: 4'd4, d: 32'd44}); exp_last = 1'b0; end
    tick;
    req0_valid = 0;
    reserve_valid = 1; reserve_reg = 4;
    tests_run++;
    if (wr_en !== 1'b1 || exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL setclr_wr_en: wr_en=%0b queued=%0d need 1", wr_en, exp_q.size());
    end else begin
      got = exp_q.pop_front();
      if (wr_reg !== got.r || wr_data !== got.d) begin
        tests_failed++;
        $display("FAIL setclr_wr: reg=%0d data=%0d need reg=%0d data=%0d", wr_reg, wr_data, got.r, got.d);
      end
    end
    tick;
    reserve_valid = 0;
    tests_run++;
    if (pending !== 16'h0010) begin
      tests_failed++;
      $display("FAIL setclr_set_wins: pending=%h need 0010", pending);
    end
    req1_valid = 1; req1_reg = 4; req1_data = 45;
    #1;
    g = exp_gnt(1'b0, 1'b1, exp_last);
    if (g[1]) begin exp_q.push_back('{r: 4'd4, d: 32'd45}); exp_last = 1'b1; end
    tick;
    req1_valid = 0;
    tests_run++;
    if (wr_en !== 1'b1 || exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL setclr_second_wr_en: wr_en=%0b queued=%0d need 1", wr_en, exp_q.size());
    end else begin
      got = exp_q.pop_front();
      if (wr_reg !== got.r || wr_data !== got.d) begin
        tests_failed++;
        $display("FAIL setclr_second_wr: reg=%0d data=%0d need reg=%0d data=%0d",
                 wr_reg, wr_data, got.r, got.d);
      end
    end
    tick;
    tests_run++;
    if (pending !== 16'h0000) begin
      tests_failed++;
      $display("FAIL setclr_final_clear: pending=%h need 0000", pending);
    end
  endtask

  task automatic test_reset_mid;
    for (int r = 1; r < 16; r++) begin
      reserve_valid = 1; reserve_reg = r[3:0];
      tick;
    end
    reserve_valid = 0;
    rd_addr_a = 1;
    #1;
    tests_run++;
    if (pending !== 16'hFFFE || rd_stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL rstmid_reserved: pending=%h stall=%0b need fffe/1", pending, rd_stall);
    end
    req0_valid = 1; req0_reg = 1; req0_data = 11;
    #1;
    g = exp_gnt(1'b1, 1'b0, exp_last);
    if (g[0]) begin exp_q.push_back('{r: 4'd1, d: 32'd11}); exp_last = 1'b0; end
    tick;
    req0_valid = 0;
    tests_run++;
    if (wr_en !== 1'b1 || exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL rstmid_wr_en: wr_en=%0b queued=%0d need 1", wr_en, exp_q.size());
    end else begin
      got = exp_q.pop_front();
      if (wr_reg !== got.r || wr_data !== got.d) begin
        tests_failed++;
        $display("FAIL rstmid_wr: reg=%0d data=%0d need reg=%0d data=%0d", wr_reg, wr_data, got.r, got.d);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (wr_en !== 1'b0 || pending !== 16'h0000 || wr_data !== 32'd0 || wr_reg !== 4'd0 || rd_stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_async: wr_en=%0b pending=%h data=%0h reg=%0d stall=%0b need all 0",
               wr_en, pending, wr_data, wr_reg, rd_stall);
    end
    tick; tick;
    tests_run++;
    if (wr_en !== 1'b0 || pending !== 16'h0000) begin
      tests_failed++;
      $display("FAIL rstmid_hold: wr_en=%0b pending=%h need 0/0000", wr_en, pending);
    end
    rst_n = 1'b1;
    exp_last = 1'b1;
    tick;
    tests_run++;
    if (wr_en !== 1'b0 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL rstmid_after: wr_en=%0b queued=%0d need 0/0", wr_en, exp_q.size());
    end
  endtask

  initial begin
    test_reset;
    test_single_alu;
    test_conflict;
    test_stall;
    test_set_clear;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
